// File: rtl/slurm16_mem_pkg.sv
// Shared types for the slurm16 memory burst reader: FSM states, bus word and address types, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package slurm16_mem_pkg;

    localparam int MEM_ADDR_BITS      = 16;
    localparam int DEFAULT_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        REQ        = 2'd2
    } state_t;

    typedef logic [MEM_ADDR_BITS-1:0] mem_addr_t;
    typedef logic [15:0]              mem_word_t;

endpackage

// File: rtl/slurm16_mem_burst_reader_if.sv
// Bundle of burst-reader control, arbiter request and consumer FIFO signals.
// Latency: n/a (wiring only).
// Backpressure: rvalid/rready toward the arbiter, out_valid/out_ready toward the consumer.
//
// Modports: master = the burst reader, slave = line logic / arbiter / consumer side.
// SLURM16_BURST_STRIDE_EN adds the 8-bit stride control input.
interface slurm16_mem_burst_reader_if
    import slurm16_mem_pkg::*;
#(
    parameter int ADDR_BITS = MEM_ADDR_BITS
);
    logic                 start;
    logic [ADDR_BITS-1:0] base_addr;
    logic [7:0]           count;
`ifdef SLURM16_BURST_STRIDE_EN
    logic [7:0]           stride;
`endif
    logic                 busy;
    logic                 done;
    logic [ADDR_BITS-1:0] memory_address;
    mem_word_t            memory_data;
    logic                 rvalid;
    logic                 rready;
    mem_word_t            out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        input  start, base_addr, count,
`ifdef SLURM16_BURST_STRIDE_EN
        input  stride,
`endif
        output busy, done,
        output memory_address, rvalid,
        input  memory_data, rready,
        output out_data, out_valid,
        input  out_ready
    );

    modport slave (
        output start, base_addr, count,
`ifdef SLURM16_BURST_STRIDE_EN
        output stride,
`endif
        input  busy, done,
        input  memory_address, rvalid,
        output memory_data, rready,
        input  out_data, out_valid,
        output out_ready
    );

endinterface

// File: rtl/slurm16_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a pushed word is visible on pop_dat/pop_vld the cycle after the push edge.
// Backpressure: push while full and pop while empty are ignored; pop_dat reads 0 when empty.
//
// Ports: clk, rst_n (async active-low); push_vld/push_dat write side;
//        pop_vld/pop_dat/pop_rdy read side; count = current occupancy (0..DEPTH).
module slurm16_sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             pop_rdy,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_vld && (count < CW'(DEPTH));
    assign pop_ok  = pop_rdy && (count != '0);
    assign pop_vld = (count != '0);
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/slurm16_mem_burst_reader.sv
// Burst read initiator for one arbiter requester port; buffers fetched words in a FWFT FIFO.
// Latency: start at t -> rvalid at t+2 when the FIFO has room; captured word on out_* one cycle later.
// Backpressure: holds rvalid/address until rready; stops requesting while the FIFO is full.
//
// Ports: CLK, RSTb (async active-low); bus (master modport): start/base_addr/count control,
//        busy/done status, memory_address/rvalid/memory_data/rready arbiter side,
//        out_data/out_valid/out_ready consumer side.
// SLURM16_BURST_STRIDE_EN: when defined, the address advances by the sampled stride instead of 1.
module slurm16_mem_burst_reader
    import slurm16_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int ADDR_BITS  = MEM_ADDR_BITS
) (
    input  logic                      CLK,
    input  logic                      RSTb,
    slurm16_mem_burst_reader_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t               state;
    logic [ADDR_BITS-1:0] addr;
    // 9 bits so that count=0 can stand for a 256-word burst.
    logic [8:0]           remaining;
    logic [ADDR_BITS-1:0] step;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     occ_after;
    logic                 fifo_push;
    logic                 fifo_pop;

    assign fifo_push = bus.rvalid && bus.rready;
    assign fifo_pop  = bus.out_valid && bus.out_ready;
    // Occupancy once the word being captured lands, net of a same-cycle consumer pop.
    assign occ_after = fifo_count + CNT_W'(1) - CNT_W'(fifo_pop);

`ifdef SLURM16_BURST_STRIDE_EN
    logic [7:0] stride_q;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            stride_q <= 8'd1;
        end else if ((state == IDLE) && bus.start) begin
            stride_q <= bus.stride;
        end
    end

    assign step = ADDR_BITS'(stride_q);
`else
    assign step = ADDR_BITS'(1);
`endif

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.rvalid <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr      <= bus.base_addr;
                        remaining <= {(bus.count == 8'd0), bus.count};
                        bus.busy  <= 1'b1;
                        state     <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
                        bus.rvalid <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // rvalid and the address stay put until the arbiter completes.
                    if (bus.rready) begin
                        addr      <= addr + step;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            state      <= IDLE;
                            bus.rvalid <= 1'b0;
                            bus.busy   <= 1'b0;
                            bus.done   <= 1'b1;
                        end else if (occ_after < CNT_W'(FIFO_DEPTH)) begin
                            state      <= REQ;
                            bus.rvalid <= 1'b1;
                        end else begin
                            state      <= WAIT_SPACE;
                            bus.rvalid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.rvalid <= 1'b0;
                    bus.busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.memory_address = addr;

    slurm16_sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RSTb),
        .push_vld (fifo_push),
        .push_dat (bus.memory_data),
        .pop_vld  (bus.out_valid),
        .pop_dat  (bus.out_data),
        .pop_rdy  (bus.out_ready),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_slurm16_mem_burst_reader.sv
// Scoreboard bench for slurm16_mem_burst_reader: directed bursts, expected requests/words queued.
// Latency: n/a (testbench).
// Backpressure: bench models a stalling arbiter and a throttled consumer.
`timescale 1ns/1ps
module tb_slurm16_mem_burst_reader;

    logic CLK = 1'b0;
    logic RSTb;
    always #5 CLK = ~CLK;

    slurm16_mem_burst_reader_if #(.ADDR_BITS(16)) bus ();

    slurm16_mem_burst_reader #(
        .FIFO_DEPTH (8),
        .ADDR_BITS  (16)
    ) dut (
        .CLK  (CLK),
        .RSTb (RSTb),
        .bus  (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_addr [$];
    logic [15:0] exp_data [$];
    int          hs_cyc [$];
    int          hs_count = 0;
    int          done_count = 0;
    int          stall_cycles = 0;
    int          cyc = 0;
    logic [15:0] last_hs_addr = 16'h0;
    logic        rready_en = 1'b0;
    logic        fixed_en = 1'b0;
    logic [15:0] fixed_dat = 16'h0;
    int          stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    logic        prev_busy = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Arbiter model: optional stall count, then rready follows rready_en; data = addr ^ 1234.
    initial begin
        bus.rready      = 1'b0;
        bus.memory_data = 16'h0;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.rvalid && stall_cnt > 0) begin
                bus.rready = 1'b0;
                stall_cnt--;
            end else begin
                bus.rready = rready_en;
            end
            bus.memory_data = fixed_en ? fixed_dat : (bus.memory_address ^ 16'h1234);
        end
    end

    // Monitor: compares every request handshake and every consumer pop against the queues.
    always @(negedge CLK) begin
        if (!RSTb) begin
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_rvalid_held", bus.rvalid, 1);
                chk("stall_addr_held", bus.memory_address, prev_addr);
            end
            if (bus.rvalid && bus.rready) begin
                hs_count++;
                hs_cyc.push_back(cyc);
                last_hs_addr = bus.memory_address;
                if (exp_addr.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL req_addr: unexpected request at %0h, none expected", bus.memory_address);
                end else begin
                    chk("req_addr", bus.memory_address, exp_addr.pop_front());
                end
            end
            if (bus.rvalid && !bus.rready) stall_cycles++;
            prev_stall = bus.rvalid && !bus.rready;
            prev_addr  = bus.memory_address;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_data.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out_data: unexpected word %0h, none expected", bus.out_data);
                end else begin
                    chk("out_data", bus.out_data, exp_data.pop_front());
                end
            end
            if (bus.done) begin
                done_count++;
                chk("done_busy_low", bus.busy, 0);
                chk("done_prev_busy", prev_busy, 1);
            end
            prev_busy = bus.busy;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [7:0] c);
        bus.base_addr = b;
        bus.count     = c;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!bus.done && n < budget) begin
            tick();
            n++;
        end
        chk(name, bus.done, 1);
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n = 0;
        while (bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        chk(name, bus.out_valid, 0);
    endtask

    task automatic expect_word(input logic [15:0] a, input logic [15:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    initial begin
        int h0;
        int d0;
        int s0;
        RSTb          = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = 16'h0;
        bus.count     = 8'h0;
        bus.out_ready = 1'b0;
`ifdef SLURM16_BURST_STRIDE_EN
        bus.stride    = 8'd1;
`endif

        // Reset values
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_addr", bus.memory_address, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        RSTb = 1'b1;
        tick();

        // Reset mid-request, with rready high during reset
        pulse_start(16'h4000, 8'd4);
        tick();
        chk("latency_rvalid", bus.rvalid, 1);
        chk("first_addr", bus.memory_address, 16'h4000);
        #1 rready_en = 1'b1;
        tick();
        #1 RSTb = 1'b0;
        #1;
        chk("async_rvalid_drop", bus.rvalid, 0);
        chk("async_busy_drop", bus.busy, 0);
        repeat (2) tick();
        chk("inrst_addr", bus.memory_address, 0);
        chk("inrst_out_valid", bus.out_valid, 0);
        RSTb = 1'b1;
        repeat (2) tick();
        chk("postrst_out_valid", bus.out_valid, 0);
        chk("postrst_rvalid", bus.rvalid, 0);

        // Back-to-back fetch with constant data
        fixed_en  = 1'b1;
        fixed_dat = 16'hdead;
        expect_word(16'h4000, 16'hdead);
        expect_word(16'h4001, 16'hdead);
        expect_word(16'h4002, 16'hdead);
        hs_cyc.delete();
        h0 = hs_count;
        d0 = done_count;
        pulse_start(16'h4000, 8'd3);
        wait_done(20, "b2b_done");
        chk("b2b_fetches", hs_count - h0, 3);
        chk("b2b_hs_logged", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) chk("b2b_consecutive", hs_cyc[2] - hs_cyc[0], 2);
        tick();
        chk("done_one_cycle", bus.done, 0);
        chk("b2b_done_count", done_count - d0, 1);
        chk("b2b_fifo_holds", bus.out_valid, 1);
        fixed_en      = 1'b0;
        bus.out_ready = 1'b1;
        wait_empty(20, "b2b_drain");

        // Stalled arbiter: 5 cycles low on the first word
        s0        = stall_cycles;
        stall_cnt = 5;
        expect_word(16'hC000, 16'hD234);
        expect_word(16'hC001, 16'hD235);
        pulse_start(16'hC000, 8'd2);
        wait_done(30, "stall_done");
        chk("stall_cycles", stall_cycles - s0, 5);
        wait_empty(20, "stall_drain");

        // Backpressure: 10 words into an 8-deep FIFO
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_word(16'h1000 + 16'(i), (16'h1000 + 16'(i)) ^ 16'h1234);
        end
        h0 = hs_count;
        pulse_start(16'h1000, 8'd10);
        repeat (20) tick();
        chk("bp_fetches_full", hs_count - h0, 8);
        chk("bp_rvalid_idle", bus.rvalid, 0);
        chk("bp_busy", bus.busy, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        repeat (5) tick();
        chk("bp_fetches_one_pop", hs_count - h0, 9);
        chk("bp_rvalid_idle2", bus.rvalid, 0);
        bus.out_ready = 1'b1;
        wait_done(40, "bp_done");
        chk("bp_fetches_total", hs_count - h0, 10);
        wait_empty(20, "bp_drain");

        // Address wrap with count=0 (256 words)
        for (int i = 0; i < 256; i++) begin
            expect_word(16'hFFFE + 16'(i), (16'hFFFE + 16'(i)) ^ 16'h1234);
        end
        h0 = hs_count;
        pulse_start(16'hFFFE, 8'd0);
        wait_done(1000, "wrap_done");
        chk("wrap_fetches", hs_count - h0, 256);
        chk("wrap_last_addr", last_hs_addr, 16'h00FD);
        wait_empty(20, "wrap_drain");

        // Start while busy is dropped; restart on the done cycle appends behind old words
        bus.out_ready = 1'b0;
        stall_cnt     = 3;
        expect_word(16'h0300, 16'h1134);
        expect_word(16'h0301, 16'h1135);
        expect_word(16'h0302, 16'h1136);
        expect_word(16'h0303, 16'h1137);
        h0 = hs_count;
        pulse_start(16'h0300, 8'd4);
        chk("busy_at_second_start", bus.busy, 1);
        pulse_start(16'h8000, 8'd1);
        wait_done(40, "ign_done");
        chk("ign_fetches", hs_count - h0, 4);
        expect_word(16'h0500, 16'h1734);
        expect_word(16'h0501, 16'h1735);
        h0 = hs_count;
        pulse_start(16'h0500, 8'd2);
        wait_done(20, "append_done");
        chk("append_fetches", hs_count - h0, 2);
        bus.out_ready = 1'b1;
        wait_empty(20, "append_drain");

`ifdef SLURM16_BURST_STRIDE_EN
        // Stride of 4
        bus.stride = 8'd4;
        expect_word(16'h0200, 16'h1034);
        expect_word(16'h0204, 16'h1030);
        expect_word(16'h0208, 16'h103C);
        h0 = hs_count;
        pulse_start(16'h0200, 8'd3);
        bus.stride = 8'd1;
        wait_done(20, "stride_done");
        chk("stride_fetches", hs_count - h0, 3);
        wait_empty(20, "stride_drain");
`endif

        repeat (3) tick();
        chk("exp_addr_left", exp_addr.size(), 0);
        chk("exp_data_left", exp_data.size(), 0);
        chk("final_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
